// File: rtl/hubris_mem_pkg.sv
// Shared definitions for the Hubris memory port-A arbiter.
//   MST_CORE / MST_DBG : master index values used for read-return routing
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   be_width()         : byte-enable width for a given data width
package hubris_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Master index: 0 = core data path, 1 = debug/loader master.
  localparam logic MST_CORE = 1'b0;
  localparam logic MST_DBG  = 1'b1;

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned BE_W_DEF = be_width(DATA_W_DEF);

endpackage

// File: rtl/hubris_arb_starve_ctr.sv
// Saturating starvation counter for the debug master.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : clear the count (has priority over increment)
//   inc_i      : count one refused cycle, saturating at LIMIT
//   limit_o    : count has reached LIMIT
module hubris_arb_starve_ctr
  import hubris_mem_pkg::*;
#(
  parameter int unsigned LIMIT = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                          cnt_d = '0;
    else if (inc_i && cnt_q != LIMIT_C) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/hubris_mem_arbiter.sv
// Port-A arbiter for the unified dual-port memory.
//   Master 0 (core data path) has fixed priority; master 1 (debug/loader)
//   is force-granted after STARVE_LIMIT refused cycles and may lock the
//   port across a burst with m1_lock.
//   m*_req/we/addr/wdata : master request (we all-zero = read)
//   m*_gnt               : combinational accept, access issued same cycle
//   m*_rvalid/rdata      : read return one cycle after a granted read
//   m1_lock              : hold ownership for master 1 after its grant
//   mem_*                : port A of the memory (1-cycle read latency)
module hubris_mem_arbiter
  import hubris_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m0_req,
  input  logic [DATA_W/8-1:0]      m0_we,
  input  logic [ADDR_W-1:0]        m0_addr,
  input  logic [DATA_W-1:0]        m0_wdata,
  output logic                     m0_gnt,
  output logic                     m0_rvalid,
  output logic [DATA_W-1:0]        m0_rdata,
  input  logic                     m1_req,
  input  logic [DATA_W/8-1:0]      m1_we,
  input  logic [ADDR_W-1:0]        m1_addr,
  input  logic [DATA_W-1:0]        m1_wdata,
  input  logic                     m1_lock,
  output logic                     m1_gnt,
  output logic                     m1_rvalid,
  output logic [DATA_W-1:0]        m1_rdata,
  output logic                     mem_en,
  output logic [DATA_W/8-1:0]      mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout
);

  logic lock_q, lock_d;
  logic rd_pending_q, rd_pending_d;
  logic rd_owner_q, rd_owner_d;
  logic starve_hit;

  hubris_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (m1_gnt | ~m1_req),
    .inc_i   (m1_req & ~m1_gnt),
    .limit_o (starve_hit)
  );

  // Grant is gated by reset so the port stays quiet while reset is held.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset) begin
      m0_gnt = 1'b0;
    end else if (lock_q) begin
      m1_gnt = m1_req;      // idle cycles inside a locked burst still block m0
    end else if (starve_hit && m1_req) begin
      m1_gnt = 1'b1;
    end else if (m0_req) begin
      m0_gnt = 1'b1;
    end else if (m1_req) begin
      m1_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en   = m0_gnt | m1_gnt;
    mem_we   = '0;
    mem_addr = m1_gnt ? m1_addr  : m0_addr;
    mem_din  = m1_gnt ? m1_wdata : m0_wdata;
    if (m1_gnt)      mem_we = m1_we;
    else if (m0_gnt) mem_we = m0_we;
  end

  // Lock is taken on a locked grant and released the first cycle m1_lock is low.
  assign lock_d       = m1_lock & (lock_q | m1_gnt);
  assign rd_pending_d = mem_en & ~(|mem_we);
  assign rd_owner_d   = m1_gnt ? MST_DBG : MST_CORE;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q       <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= MST_CORE;
    end else begin
      lock_q       <= lock_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // A read granted just before reset must not return while reset is high.
  assign m0_rvalid = ~reset & rd_pending_q & (rd_owner_q == MST_CORE);
  assign m1_rvalid = ~reset & rd_pending_q & (rd_owner_q == MST_DBG);
  assign m0_rdata  = mem_dout;
  assign m1_rdata  = mem_dout;

endmodule

// File: doc/hubris_mem_arbiter.md
Name: hubris_mem_arbiter

Overview:
- Arbitrates the general-use port (port A) of the unified dual-port memory between two masters.
  - Master 0 is the Hubris core data path (loads/stores).
  - Master 1 is a debug/loader master (program load, memory dump, DMA).
- Port B (instruction fetch) is not touched.
- Master 0 has fixed priority, bounded by a starvation counter.
- Master 1 may lock the port for multi-word bursts.
- Read data is routed back with the memory's 1-cycle synchronous latency.

Parameters:
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width; byte enable width is DATA_W/8
- STARVE_LIMIT, 8, consecutive cycles master 1 may be refused before it is force-granted
- CNT_W, 4, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 access request
- m0_we  in  DATA_W/8  byte write enables; all zero means read
- m0_addr  in  ADDR_W  address
- m0_wdata  in  DATA_W  write data
- m0_gnt  out  1  access accepted this cycle
- m0_rvalid  out  1  read data valid (one cycle after a granted read)
- m0_rdata  out  DATA_W  read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as master 0
- m1_lock  in  1  keep the port owned by master 1 after its current grant
- mem_en  out  1  to port A en
- mem_we  out  DATA_W/8  to port A we
- mem_addr  out  ADDR_W  to port A addr
- mem_din  out  DATA_W  to port A din
- mem_dout  in  DATA_W  from port A dout (valid the cycle after en)

Behaviour:
- Grant is combinational from req and registered state.
  - A transfer occurs when req and gnt are both high; the access is issued to memory in that same cycle.
  - mem_en = m0_gnt | m1_gnt.
  - mem_we, mem_addr and mem_din are muxed from the granted master.
  - When neither master is granted, mem_we is zero.
- At most one gnt is high per cycle.
- Arbitration order, first match wins:
  1. lock_held: m1_gnt = m1_req; m0_gnt = 0.
  2. Starvation cap: starve_cnt == STARVE_LIMIT and m1_req → m1 is granted.
  3. m0_req → m0 is granted.
  4. m1_req → m1 is granted.
- lock_held register:
  - Set on a cycle where m1 is granted and m1_lock = 1.
  - Cleared on any cycle where m1_lock = 0.
  - While set, m0 is refused even if m1_req is low (idle cycles inside the burst).
- starve_cnt register:
  - Increments while m1_req = 1 and m1_gnt = 0, saturating at STARVE_LIMIT.
  - Cleared when m1 is granted or m1_req = 0.
- Read return:
  - rd_owner and rd_pending are registered on every cycle.
  - rd_pending = granted access with we == 0; rd_owner = the granted master index.
  - Next cycle, mx_rvalid = rd_pending & (rd_owner == x).
  - m0_rdata and m1_rdata both drive mem_dout directly; qualify with rvalid.
- Writes: complete at grant; no rvalid is produced.
- Back-to-back: a new grant may be issued the same cycle rvalid is returned for the previous read, giving full throughput of one access per cycle.
- Masters must hold req, we, addr and wdata stable until gnt.
- Reset:
  - All gnt, rvalid and mem_en outputs are 0.
  - starve_cnt = 0, lock_held = 0, rd_pending = 0.
  - Reset mid-operation discards any pending rvalid; no rvalid fires in the cycle after reset deasserts.
- m1_lock asserted without a grant has no effect until m1 is granted.
- Simultaneous m0_req and m1_req with starve_cnt < STARVE_LIMIT and no lock: m0 wins; starve_cnt increments.

Decomposition:
- Shared package hubris_mem_pkg holds:
  - Master index constants MST_CORE = 0 and MST_DBG = 1.
  - Default ADDR_W and DATA_W.
  - A byte-enable-width helper constant.
- One sub-module is natural: hubris_arb_starve_ctr (saturating counter with clear, increment and limit-reached output).
- Grant logic, lock and response routing stay in the top module.

Test Plan:
- Only m0 reads address 0x100, mem holds 0xDEADBEEF:
  - m0_gnt = 1 in the same cycle.
  - Next cycle m0_rvalid = 1, m0_rdata = 0xDEADBEEF, m1_rvalid = 0.
- m0_req and m1_req both held high continuously:
  - m0 is granted 8 cycles.
  - On cycle 9, m1_gnt = 1 and m0_gnt = 0; starve_cnt then returns to 0.
- m1 writes 4 words with m1_lock = 1, m1_req dropped for 2 cycles mid-burst, and m0_req high throughout:
  - m0_gnt stays 0 until m1_lock drops.
  - m0 is granted the cycle after m1_lock drops.
- Alternating m0 read of 0x0 and m1 read of 0x4 in consecutive cycles:
  - rvalid alternates m0, m1 with data mem[0] and mem[1].
  - No cross-routing between masters.
- m0 write, we = 4'b0011, data 0xAABBCCDD to 0x8 over 0x11223344 → a later read returns 0x1122CCDD; no rvalid follows the write.
- reset asserted the cycle after a granted m1 read → m1_rvalid stays 0; all outputs are 0 during reset and in the first post-reset cycle with no requests.
